l1_instr_dat_banked: RTL and testbench

Parametrised L1 instruction data array with even/odd line banks.
- Every accepted read returns a FETCH_WIDTH window at any halfword offset of line idx, spilling into line idx+1 when needed. This supports fetch across line boundaries, e.g. compressed plus 32-bit instructions.
- Line refill arrives as multi-beat valid/ready traffic, is assembled in a line buffer, and is committed atomically, so reads never see a partial line.
- Sits between the fetch stage and the L1 instruction tag/refill controller.

---
 rtl/l1_icache_pkg.sv | 19 +
 rtl/l1_instr_bank.sv | 27 ++
 rtl/l1_instr_dat_banked.sv | 151 +++++++++++++++
 tb/tb_l1_instr_dat_banked.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_icache_pkg.sv
// Shared types and constants for the L1 instruction cache data path.
package l1_icache_pkg;

  localparam int unsigned HW_WIDTH       = 16;
  localparam int unsigned DEF_LINE_WIDTH = 128;
  localparam int unsigned DEF_IDX_WIDTH  = 6;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } fill_state_e;

  function automatic int unsigned beats_per_line(input int unsigned line_w,
                                                 input int unsigned beat_w);
    return line_w / beat_w;
  endfunction

endpackage

// File: rtl/l1_instr_bank.sv
// Single-port line RAM: registered read, full-line write; write wins over read.
module l1_instr_bank #(
  parameter int AW = 5,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Only the read register is reset; the array contents are left as-is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata <= '0;
    else if (re && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/l1_instr_dat_banked.sv
// L1 instruction data array: even/odd line banks, halfword-aligned fetch window
// that may spill into the next line, and atomic multi-beat line refill.
module l1_instr_dat_banked
  import l1_icache_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
  parameter int FETCH_WIDTH = 32,
  parameter int BEAT_WIDTH  = 32,
  parameter int OFF_WIDTH   = $clog2(LINE_WIDTH / HW_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_valid_i,
  output logic                   rd_ready_o,
  input  logic [IDX_WIDTH-1:0]   rd_idx_i,
  input  logic [OFF_WIDTH-1:0]   rd_off_i,
  output logic                   rd_valid_o,
  output logic [FETCH_WIDTH-1:0] rd_data_o,
  output logic                   rd_cross_o,
  input  logic                   fill_start_i,
  input  logic [IDX_WIDTH-1:0]   fill_idx_i,
  input  logic                   fill_valid_i,
  output logic                   fill_ready_o,
  input  logic [BEAT_WIDTH-1:0]  fill_data_i,
  output logic                   fill_busy_o,
  output logic                   fill_done_o
);

  localparam int BEATS = beats_per_line(LINE_WIDTH, BEAT_WIDTH);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BA_W  = IDX_WIDTH - 1;

  fill_state_e state, state_nxt;

  logic [CNT_W-1:0]      beat_q;
  logic [IDX_WIDTH-1:0]  fill_idx_q;
  logic [LINE_WIDTH-1:0] line_buf;
  logic                  beat_acc;
  logic                  rd_acc;

  logic [OFF_WIDTH-1:0]  off_q;
  logic                  odd_first_q;
  logic [BA_W-1:0]       rd_hi, rd_hi_nxt;
  logic [BA_W-1:0]       even_addr, odd_addr;
  logic                  even_we, odd_we;
  logic [LINE_WIDTH-1:0] even_rdata, odd_rdata;
  logic [LINE_WIDTH-1:0] lo_line, hi_line;
  logic [OFF_WIDTH+3:0]  shamt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fill_ready_o = 1'b0;
    fill_busy_o  = 1'b0;
    fill_done_o  = 1'b0;
    rd_ready_o   = 1'b1;
    case (state)
      IDLE: begin
        if (fill_start_i) state_nxt = FILL;
      end
      FILL: begin
        fill_ready_o = 1'b1;
        fill_busy_o  = 1'b1;
        if (fill_valid_i && beat_q == CNT_W'(BEATS - 1)) state_nxt = COMMIT;
      end
      COMMIT: begin
        fill_busy_o = 1'b1;
        fill_done_o = 1'b1;
        rd_ready_o  = 1'b0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat_acc = fill_valid_i && fill_ready_o;
  assign rd_acc   = rd_valid_i && rd_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q     <= '0;
      fill_idx_q <= '0;
    end else if (state == IDLE && fill_start_i) begin
      beat_q     <= '0;
      fill_idx_q <= fill_idx_i;
    end else if (beat_acc) begin
      beat_q     <= beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (beat_acc) line_buf[int'(beat_q) * BEAT_WIDTH +: BEAT_WIDTH] <= fill_data_i;
  end

  // Line idx and idx+1 always sit in opposite banks; only the even bank ever
  // needs the incremented row (odd idx), which also covers the wrap to line 0.
  assign rd_hi     = rd_idx_i[IDX_WIDTH-1:1];
  assign rd_hi_nxt = rd_hi + BA_W'(rd_idx_i[0]);

  assign even_we   = (state == COMMIT) && !fill_idx_q[0];
  assign odd_we    = (state == COMMIT) &&  fill_idx_q[0];
  assign even_addr = even_we ? fill_idx_q[IDX_WIDTH-1:1] : rd_hi_nxt;
  assign odd_addr  = odd_we  ? fill_idx_q[IDX_WIDTH-1:1] : rd_hi;

  l1_instr_bank #(.AW(BA_W), .DW(LINE_WIDTH)) u_even_bank (
    .clk   (clk_i),
    .rst   (rst_i),
    .re    (rd_acc),
    .we    (even_we),
    .addr  (even_addr),
    .wdata (line_buf),
    .rdata (even_rdata)
  );

  l1_instr_bank #(.AW(BA_W), .DW(LINE_WIDTH)) u_odd_bank (
    .clk   (clk_i),
    .rst   (rst_i),
    .re    (rd_acc),
    .we    (odd_we),
    .addr  (odd_addr),
    .wdata (line_buf),
    .rdata (odd_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_valid_o  <= 1'b0;
      off_q       <= '0;
      odd_first_q <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      if (rd_acc) begin
        off_q       <= rd_off_i;
        odd_first_q <= rd_idx_i[0];
      end
    end
  end

  // Bank outputs and off_q only move on accept, so the window holds between reads.
  assign lo_line    = odd_first_q ? odd_rdata  : even_rdata;
  assign hi_line    = odd_first_q ? even_rdata : odd_rdata;
  assign shamt      = {off_q, 4'b0000};
  assign rd_data_o  = FETCH_WIDTH'({hi_line, lo_line} >> shamt);
  assign rd_cross_o = (int'(shamt) + FETCH_WIDTH) > LINE_WIDTH;

endmodule

// File: tb/tb_l1_instr_dat_banked.sv
// Randomized and directed bench for l1_instr_dat_banked against a line-level model.
module tb_l1_instr_dat_banked;

  localparam int LW = 128;
  localparam int IW = 6;
  localparam int FW = 32;
  localparam int BW = 32;
  localparam int OW = 3;
  localparam int NL = 64;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rd_valid_i = 1'b0;
  logic          rd_ready_o;
  logic [IW-1:0] rd_idx_i = '0;
  logic [OW-1:0] rd_off_i = '0;
  logic          rd_valid_o;
  logic [FW-1:0] rd_data_o;
  logic          rd_cross_o;
  logic          fill_start_i = 1'b0;
  logic [IW-1:0] fill_idx_i = '0;
  logic          fill_valid_i = 1'b0;
  logic          fill_ready_o;
  logic [BW-1:0] fill_data_i = '0;
  logic          fill_busy_o;
  logic          fill_done_o;

  l1_instr_dat_banked #(
    .LINE_WIDTH (LW),
    .IDX_WIDTH  (IW),
    .FETCH_WIDTH(FW),
    .BEAT_WIDTH (BW),
    .OFF_WIDTH  (OW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rd_valid_i  (rd_valid_i),
    .rd_ready_o  (rd_ready_o),
    .rd_idx_i    (rd_idx_i),
    .rd_off_i    (rd_off_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_cross_o  (rd_cross_o),
    .fill_start_i(fill_start_i),
    .fill_idx_i  (fill_idx_i),
    .fill_valid_i(fill_valid_i),
    .fill_ready_o(fill_ready_o),
    .fill_data_i (fill_data_i),
    .fill_busy_o (fill_busy_o),
    .fill_done_o (fill_done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line-level model: committed line contents, pending refill, expected outputs.
  logic [LW-1:0] mem_m [NL];
  bit            known [NL];
  logic [LW-1:0] pre   [NL];
  bit            m_in_fill = 0;
  bit            m_commit  = 0;
  int            m_tgt     = 0;
  int            m_nbeats  = 0;
  logic [LW-1:0] m_buf     = '0;
  logic          exp_valid = 1'b0;
  logic [FW-1:0] exp_data  = '0;
  logic          exp_cross = 1'b0;
  bit            exp_known = 1;
  int            m_i, m_o;

  function automatic logic [FW-1:0] window(input int idx, input int off);
    logic [2*LW-1:0] two;
    two = {mem_m[(idx + 1) % NL], mem_m[idx]};
    two = two >> (16 * off);
    return two[FW-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_in_fill = 0;
      m_commit  = 0;
      m_nbeats  = 0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_cross = 1'b0;
      exp_known = 1;
    end else begin
      m_i = int'(rd_idx_i);
      m_o = int'(rd_off_i);
      if (rd_valid_i && !m_commit) begin
        exp_valid = 1'b1;
        exp_known = known[m_i] && known[(m_i + 1) % NL];
        exp_data  = window(m_i, m_o);
        exp_cross = (16 * m_o + FW) > LW;
      end else begin
        exp_valid = 1'b0;
      end
      if (m_commit) begin
        mem_m[m_tgt] = m_buf;
        known[m_tgt] = 1;
        m_commit     = 0;
      end else if (m_in_fill) begin
        if (fill_valid_i) begin
          m_buf[m_nbeats * BW +: BW] = fill_data_i;
          m_nbeats++;
          if (m_nbeats == LW / BW) begin
            m_in_fill = 0;
            m_commit  = 1;
          end
        end
      end else if (fill_start_i) begin
        m_in_fill = 1;
        m_tgt     = int'(fill_idx_i);
        m_nbeats  = 0;
      end
      #1;
      if (!rst_i) begin
        chk("rd_valid", rd_valid_o, exp_valid);
        if (exp_known) chk("rd_data", rd_data_o, exp_data);
        chk("rd_cross", rd_cross_o, exp_cross);
        chk("rd_ready", rd_ready_o, !m_commit);
        chk("fill_ready", fill_ready_o, m_in_fill);
        chk("fill_busy", fill_busy_o, m_in_fill || m_commit);
        chk("fill_done", fill_done_o, m_commit);
      end
    end
  end

  // Starts and ends on a falling edge; pat bit k = fill_valid_i in the k-th FILL cycle.
  task automatic fill_line(input int idx, input logic [LW-1:0] line, input logic [15:0] pat,
                           input bit poke, input bit zchk, output int nready,
                           output logic done_at_end, output logic rdy_at_commit,
                           output logic busy_after);
    int beat;
    int k;
    @(negedge clk);
    fill_start_i = 1'b1;
    fill_idx_i   = IW'(idx);
    @(negedge clk);
    fill_start_i = 1'b0;
    beat   = 0;
    k      = 0;
    nready = 0;
    while (beat < LW / BW && k < 64) begin
      if (fill_ready_o) nready++;
      if (zchk) chk("read_during_fill_old", {rd_valid_o, rd_data_o}, {1'b1, 32'h0});
      fill_valid_i = pat[k % 16];
      fill_data_i  = pat[k % 16] ? line[beat * BW +: BW] : $urandom();
      if (poke && k == 1) begin
        fill_start_i = 1'b1;
        fill_idx_i   = IW'(idx ^ 1);
      end
      @(negedge clk);
      fill_start_i = 1'b0;
      if (pat[k % 16]) beat++;
      k++;
    end
    if (beat < LW / BW) chk("fill_beat_budget", beat, LW / BW);
    fill_valid_i  = 1'b0;
    done_at_end   = fill_done_o;
    rdy_at_commit = rd_ready_o;
    @(negedge clk);
    busy_after = fill_busy_o;
  endtask

  task automatic do_read(input int idx, input int off, output logic [FW-1:0] d, output logic c);
    rd_valid_i = 1'b1;
    rd_idx_i   = IW'(idx);
    rd_off_i   = OW'(off);
    @(negedge clk);
    rd_valid_i = 1'b0;
    chk("read_valid", rd_valid_o, 1'b1);
    d = rd_data_o;
    c = rd_cross_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int            nready;
    logic          done_e, rdy_c, busy_a;
    logic [FW-1:0] d;
    logic          c;
    logic [LW-1:0] line_d, line_e, line_f, line_1;

    repeat (2) @(negedge clk);
    chk("reset_rd_valid", rd_valid_o, 1'b0);
    chk("reset_rd_data", rd_data_o, 32'h0);
    chk("reset_rd_cross", rd_cross_o, 1'b0);
    chk("reset_fill_ready", fill_ready_o, 1'b0);
    chk("reset_fill_busy", fill_busy_o, 1'b0);
    chk("reset_fill_done", fill_done_o, 1'b0);
    rst_i = 1'b0;

    for (int i = 0; i < NL; i++) begin
      pre[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (i == 5) pre[i] = '0;
      if (i == 6) pre[i] = {8{16'hAAAA}};
      if (i == 7) pre[i] = {8{16'hBBBB}};
      if (i == 0) pre[i][15:0] = 16'h0000;
      if (i == 63) for (int h = 0; h < 8; h++) pre[i][h * 16 +: 16] = 16'h6300 + 16'(h);
      fill_line(i, pre[i], 16'hFFFF, 0, 0, nready, done_e, rdy_c, busy_a);
    end

    // Continuous reads of line 5 across its refill.
    line_d = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    rd_idx_i   = IW'(5);
    rd_off_i   = '0;
    rd_valid_i = 1'b1;
    fill_line(5, line_d, 16'hFFFF, 0, 1, nready, done_e, rdy_c, busy_a);
    chk("commit_rd_ready_low", rdy_c, 1'b0);
    chk("no_accept_in_commit", rd_valid_o, 1'b0);
    @(negedge clk);
    chk("read_after_commit_new", rd_data_o, 32'h89ABCDEF);
    rd_valid_i = 1'b0;

    line_1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    fill_line(5, line_1, 16'hFFFF, 0, 0, nready, done_e, rdy_c, busy_a);
    chk("fill_ready_cycles", nready, 4);
    chk("fill_done_pulse", done_e, 1'b1);
    chk("fill_busy_after", busy_a, 1'b0);
    do_read(5, 0, d, c);
    chk("idx5_off0_data", d, 32'h11111111);
    chk("idx5_off0_cross", c, 1'b0);

    do_read(6, 7, d, c);
    chk("idx6_off7_data", d, 32'hBBBBAAAA);
    chk("idx6_off7_cross", c, 1'b1);

    do_read(63, 7, d, c);
    chk("wrap_data", d, 32'h00006307);
    chk("wrap_cross", c, 1'b1);

    // Gapped beats 1,0,0,1,1,0,1 plus an ignored start pulse mid-fill.
    line_e = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
    fill_line(12, line_e, 16'h0059, 1, 0, nready, done_e, rdy_c, busy_a);
    chk("gap_fill_ready_cycles", nready, 7);
    chk("gap_fill_done", done_e, 1'b1);
    do_read(12, 0, d, c);
    chk("gap_beat0", d, 32'hA1A1A1A1);
    do_read(12, 2, d, c);
    chk("gap_beat1", d, 32'hB2B2B2B2);
    do_read(12, 4, d, c);
    chk("gap_beat2", d, 32'hC3C3C3C3);
    do_read(12, 6, d, c);
    chk("gap_beat3", d, 32'hD4D4D4D4);
    do_read(13, 0, d, c);
    chk("poke_idx_untouched", d, pre[13][31:0]);

    // Reset mid-refill of line 9 while reading line 8 with spill into 9.
    line_f = {4{32'h99999999}};
    rd_idx_i   = IW'(8);
    rd_off_i   = OW'(7);
    rd_valid_i = 1'b1;
    @(negedge clk);
    fill_start_i = 1'b1;
    fill_idx_i   = IW'(9);
    @(negedge clk);
    fill_start_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      fill_valid_i = 1'b1;
      fill_data_i  = line_f[b * BW +: BW];
      @(negedge clk);
    end
    fill_valid_i = 1'b0;
    chk("spill_old_idx9", rd_data_o, {pre[9][15:0], pre[8][127:112]});
    rst_i = 1'b1;
    #1;
    chk("abort_busy", fill_busy_o, 1'b0);
    chk("abort_rd_valid", rd_valid_o, 1'b0);
    chk("abort_fill_ready", fill_ready_o, 1'b0);
    @(negedge clk);
    rst_i      = 1'b0;
    rd_valid_i = 1'b0;
    do_read(9, 0, d, c);
    chk("abort_line9_lo", d, pre[9][31:0]);
    do_read(9, 4, d, c);
    chk("abort_line9_mid", d, pre[9][95:64]);

    for (int n = 0; n < 400; n++) begin
      rd_valid_i   = 1'($urandom_range(0, 1));
      rd_idx_i     = IW'($urandom());
      rd_off_i     = OW'($urandom());
      fill_start_i = ($urandom_range(0, 7) == 0);
      fill_idx_i   = IW'($urandom());
      fill_valid_i = 1'($urandom_range(0, 1));
      fill_data_i  = $urandom();
      @(negedge clk);
    end
    rd_valid_i   = 1'b0;
    fill_start_i = 1'b0;
    fill_valid_i = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
